my_mem_ctrl: RTL and testbench

MY_MEM_CTRL -- requirements
Module: my_mem_ctrl

---
 rtl/my_mem_ctrl_if.sv | 29 ++
 rtl/my_mem_ctrl.sv | 116 +++++++++++
 tb/tb_my_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/my_mem_ctrl_if.sv
// Request, memory-side and response signals shared by a requester, my_mem_ctrl and my_mem.
interface my_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_address;
   logic [7:0]  mem_data_in;
   logic [8:0]  mem_data_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_parity_err;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_data_out, rsp_ready,
      output req_ready, mem_write, mem_read, mem_address, mem_data_in,
             rsp_valid, rsp_data, rsp_parity_err
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_data_out, rsp_ready,
      input  req_ready, mem_write, mem_read, mem_address, mem_data_in,
             rsp_valid, rsp_data, rsp_parity_err
   );
endinterface

// File: rtl/my_mem_ctrl.sv
// Single-request controller for my_mem: one write or read at a time, even-parity check on
// read data, saturating parity-error count and wrapping write/read counts.
module my_mem_ctrl #(
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   my_mem_ctrl_if.slave        bus,
   output logic [7:0]          err_count_o,
   output logic [15:0]         wr_count_o,
   output logic [15:0]         rd_count_o
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_e;

   localparam logic [3:0] WaitInit = 4'(READ_LATENCY - 1);

   state_e      state_q;
   logic [3:0]  wait_cnt_q;
   logic        mem_write_q;
   logic        mem_read_q;
   logic [15:0] mem_address_q;
   logic [7:0]  mem_data_in_q;
   logic        rsp_valid_q;
   logic [7:0]  rsp_data_q;
   logic        rsp_parity_err_q;
   logic [7:0]  err_count_q;
   logic [15:0] wr_count_q;
   logic [15:0] rd_count_q;

   logic        req_ready;
   logic        parity_err_d;
   logic [7:0]  err_count_d;

   assign req_ready    = (state_q == IDLE) && !rst;
   assign parity_err_d = ^bus.mem_data_out;
   // Saturate at 255 rather than wrap.
   assign err_count_d  = (parity_err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1
                                                                  : err_count_q;

   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         wait_cnt_q       <= 4'd0;
         mem_write_q      <= 1'b0;
         mem_read_q       <= 1'b0;
         mem_address_q    <= 16'd0;
         mem_data_in_q    <= 8'd0;
         rsp_valid_q      <= 1'b0;
         rsp_data_q       <= 8'd0;
         rsp_parity_err_q <= 1'b0;
         err_count_q      <= 8'd0;
         wr_count_q       <= 16'd0;
         rd_count_q       <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid && req_ready) begin
                  mem_address_q <= bus.req_addr;
                  mem_data_in_q <= bus.req_wdata;
                  if (bus.req_write) begin
                     mem_write_q <= 1'b1;
                     state_q     <= WRITE;
                  end else begin
                     mem_read_q <= 1'b1;
                     state_q    <= READ;
                  end
               end
            end
            WRITE: begin
               mem_write_q <= 1'b0;
               wr_count_q  <= wr_count_q + 16'd1;
               state_q     <= IDLE;
            end
            READ: begin
               mem_read_q <= 1'b0;
               wait_cnt_q <= WaitInit;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt_q == 4'd0) begin
                  rsp_data_q       <= bus.mem_data_out[7:0];
                  rsp_parity_err_q <= parity_err_d;
                  err_count_q      <= err_count_d;
                  rd_count_q       <= rd_count_q + 16'd1;
                  rsp_valid_q      <= 1'b1;
                  state_q          <= RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready      = req_ready;
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_read       = mem_read_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_data_in    = mem_data_in_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_data       = rsp_data_q;
   assign bus.rsp_parity_err = rsp_parity_err_q;
   assign err_count_o        = err_count_q;
   assign wr_count_o         = wr_count_q;
   assign rd_count_o         = rd_count_q;

endmodule

// File: tb/tb_my_mem_ctrl.sv
// Bench for my_mem_ctrl: two instances (read latency 1 and 3) sharing one driver, a parity
// memory model and a response scoreboard fed by the stimulus and drained by a monitor.
module tb_my_mem_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst3;
   my_mem_ctrl_if m1 ();
   my_mem_ctrl_if m3 ();
   logic [7:0]  err1, err3;
   logic [15:0] wr1, wr3, rd1, rd3;

   my_mem_ctrl #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst1), .bus(m1),
      .err_count_o(err1), .wr_count_o(wr1), .rd_count_o(rd1)
   );

   my_mem_ctrl #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst3), .bus(m3),
      .err_count_o(err3), .wr_count_o(wr3), .rd_count_o(rd3)
   );

   // Shared driver; sel picks which instance sees req_valid and which one is observed.
   logic        sel;
   logic        drv_valid, drv_write, drv_rsp_ready, corrupt;
   logic [15:0] drv_addr;
   logic [7:0]  drv_wdata;

   assign m1.req_valid = drv_valid & ~sel;
   assign m3.req_valid = drv_valid & sel;
   assign m1.req_write = drv_write;
   assign m3.req_write = drv_write;
   assign m1.req_addr  = drv_addr;
   assign m3.req_addr  = drv_addr;
   assign m1.req_wdata = drv_wdata;
   assign m3.req_wdata = drv_wdata;
   assign m1.rsp_ready = drv_rsp_ready;
   assign m3.rsp_ready = drv_rsp_ready;

   // my_mem model: stores even parity with each byte; corrupt flips the parity bit on reads.
   logic [8:0] mem_model [0:65535];
   logic [8:0] rd1_q, rd3_q;
   assign m1.mem_data_out = rd1_q ^ {corrupt, 8'h00};
   assign m3.mem_data_out = rd3_q ^ {corrupt, 8'h00};

   always @(posedge clk) begin
      if (m1.mem_write) mem_model[m1.mem_address] <= {^m1.mem_data_in, m1.mem_data_in};
      if (m3.mem_write) mem_model[m3.mem_address] <= {^m3.mem_data_in, m3.mem_data_in};
      if (m1.mem_read)  rd1_q <= mem_model[m1.mem_address];
      if (m3.mem_read)  rd3_q <= mem_model[m3.mem_address];
   end

   logic        s_req_ready, s_mem_write, s_mem_read, s_rsp_valid, s_rsp_perr;
   logic [15:0] s_addr, s_wr, s_rd;
   logic [7:0]  s_wdata, s_rsp_data, s_err;
   assign s_req_ready = sel ? m3.req_ready      : m1.req_ready;
   assign s_mem_write = sel ? m3.mem_write      : m1.mem_write;
   assign s_mem_read  = sel ? m3.mem_read       : m1.mem_read;
   assign s_rsp_valid = sel ? m3.rsp_valid      : m1.rsp_valid;
   assign s_rsp_perr  = sel ? m3.rsp_parity_err : m1.rsp_parity_err;
   assign s_rsp_data  = sel ? m3.rsp_data       : m1.rsp_data;
   assign s_addr      = sel ? m3.mem_address    : m1.mem_address;
   assign s_wdata     = sel ? m3.mem_data_in    : m1.mem_data_in;
   assign s_err       = sel ? err3 : err1;
   assign s_wr        = sel ? wr3  : wr1;
   assign s_rd        = sel ? rd3  : rd1;

   int n_checks = 0;
   int n_errors = 0;
   logic [8:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic score(input logic [7:0] d, input logic pe);
      logic [8:0] e;
      if (exp_q.size() == 0) begin
         check("rsp_unexpected", 32'(exp_q.size()), 1);
      end else begin
         e = exp_q.pop_front();
         check("rsp_data", 32'(d), 32'(e[7:0]));
         check("rsp_parity_err", 32'(pe), 32'(e[8]));
      end
   endtask

   // Monitor: a response is consumed at the edge following a negedge with valid and ready high.
   always @(negedge clk) begin
      if (m1.rsp_valid && m1.rsp_ready) score(m1.rsp_data, m1.rsp_parity_err);
      if (m3.rsp_valid && m3.rsp_ready) score(m3.rsp_data, m3.rsp_parity_err);
      if (m1.mem_write || m1.mem_read) check("mem_rw_excl1", 32'(m1.mem_write & m1.mem_read), 0);
      if (m3.mem_write || m3.mem_read) check("mem_rw_excl3", 32'(m3.mem_write & m3.mem_read), 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!s_req_ready && n < 100) begin
         tick();
         n++;
      end
      check(name, 32'(s_req_ready), 1);
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
      drv_write = w;
      drv_addr  = a;
      drv_wdata = d;
      drv_valid = 1'b1;
      wait_ready("req_ready_wait");
      tick();
      drv_valid = 1'b0;
      check(w ? "mem_write_on" : "mem_read_on", 32'(w ? s_mem_write : s_mem_read), 1);
      check("mem_address", 32'(s_addr), 32'(a));
      if (w) check("mem_data_in", 32'(s_wdata), 32'(d));
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      issue(1'b1, a, d);
      tick();
      check("mem_write_pulse", 32'(s_mem_write), 0);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [8:0] exp, input bit expect_rsp);
      if (expect_rsp) exp_q.push_back(exp);
      issue(1'b0, a, 8'h00);
   endtask

   logic [15:0] va [6] = '{16'h0001, 16'hBEEF, 16'h8000, 16'h00FF, 16'hFFFF, 16'h4242};
   logic [7:0]  vd [6] = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h5A};

   task automatic write_then_read_six(input string tag);
      for (int i = 0; i < 6; i++) do_write(va[i], vd[i]);
      for (int i = 0; i < 6; i++) do_read(va[i], {1'b0, vd[i]}, 1'b1);
      wait_ready({tag, "_idle"});
      check({tag, "_wr_count"}, 32'(s_wr), 6);
      check({tag, "_rd_count"}, 32'(s_rd), 6);
      check({tag, "_err_count"}, 32'(s_err), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel = 1'b0;
      drv_valid = 1'b0; drv_write = 1'b0; drv_addr = 16'h0; drv_wdata = 8'h0;
      drv_rsp_ready = 1'b1; corrupt = 1'b0;
      rd1_q = 9'h0; rd3_q = 9'h0;
      rst1 = 1'b1; rst3 = 1'b1;
      tick();
      tick();
      check("req_ready_in_rst", 32'(s_req_ready), 0);
      rst1 = 1'b0; rst3 = 1'b0;
      #1;
      check("rst_req_ready", 32'(s_req_ready), 1);
      check("rst_mem_write", 32'(s_mem_write), 0);
      check("rst_mem_read", 32'(s_mem_read), 0);
      check("rst_rsp_valid", 32'(s_rsp_valid), 0);
      check("rst_rsp_perr", 32'(s_rsp_perr), 0);
      check("rst_mem_address", 32'(s_addr), 0);
      check("rst_mem_data_in", 32'(s_wdata), 0);
      check("rst_rsp_data", 32'(s_rsp_data), 0);
      check("rst_counts", 32'({s_err, s_wr, s_rd}), 0);

      // Basic write, then a read of the same location with latency tracking.
      do_write(16'h1234, 8'hA5);
      check("wr_count_1", 32'(s_wr), 1);
      do_read(16'h1234, 9'h0A5, 1'b1);
      tick();
      check("mem_read_pulse", 32'(s_mem_read), 0);
      check("rsp_valid_n1", 32'(s_rsp_valid), 0);
      tick();
      check("rsp_valid_n2", 32'(s_rsp_valid), 1);
      check("rd_count_1", 32'(s_rd), 1);
      check("err_count_0", 32'(s_err), 0);
      wait_ready("idle_after_read");

      // Downstream back-pressure; req_* wiggles meanwhile must not matter.
      drv_rsp_ready = 1'b0;
      do_read(16'h1234, 9'h0A5, 1'b1);
      for (int n = 0; n < 20 && !s_rsp_valid; n++) tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_rsp_valid", 32'(s_rsp_valid), 1);
         check("stall_rsp_data", 32'(s_rsp_data), 'hA5);
         check("stall_req_ready", 32'(s_req_ready), 0);
         check("stall_mem_address", 32'(s_addr), 'h1234);
         drv_addr  = 16'h0F00 + 16'(i);
         drv_wdata = 8'(i);
         tick();
      end
      drv_rsp_ready = 1'b1;
      tick();
      check("stall_release_valid", 32'(s_rsp_valid), 0);
      check("stall_release_ready", 32'(s_req_ready), 1);
      check("addr_hold_idle", 32'(s_addr), 'h1234);
      check("rd_count_2", 32'(s_rd), 2);

      // Parity errors: one, then 299 more to reach saturation.
      corrupt = 1'b1;
      do_read(16'h1234, 9'h1A5, 1'b1);
      wait_ready("idle_after_perr");
      check("err_count_1", 32'(s_err), 1);
      for (int i = 0; i < 299; i++) do_read(16'h1234, 9'h1A5, 1'b1);
      wait_ready("idle_after_perr_burst");
      check("err_count_sat", 32'(s_err), 255);
      check("rd_count_302", 32'(s_rd), 302);
      corrupt = 1'b0;

      // Reset during WAIT aborts the read with no response.
      do_read(16'h1234, 9'h0A5, 1'b0);
      tick();
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      #1;
      check("abort_req_ready", 32'(s_req_ready), 1);
      check("abort_rsp_valid", 32'(s_rsp_valid), 0);
      check("abort_rd_count", 32'(s_rd), 0);
      check("abort_err_count", 32'(s_err), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_rsp", 32'(s_rsp_valid), 0);
      end

      // Six writes then six reads on each latency.
      write_then_read_six("lat1");
      sel = 1'b1;
      #1;
      write_then_read_six("lat3");

      repeat (5) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
